// File: rtl/hazard_scoreboard.sv
// Long-latency destination tracker for ID: stalls decode on RAW/WAW/capacity
// hazards against registers whose LOAD/PIM results have not yet been written back.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   id_*  : instruction held in ID (valid, opcode, rs1, rs2, rd, long-latency flag)
//   flush_i : squash the ID instruction this cycle
//   wb_*  : writeback (reg_write, rd, long-latency retire flag)
//   stall_o (combinational), pending_o bitmap, outstanding_o, full_o, err_o (sticky)
module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_long_lat_i,
  input  logic             flush_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_long_lat_i,
  output logic             stall_o,
  output logic [31:0]      pending_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_PIM    = 7'b0001011;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  logic        rs1_used;
  logic        rs2_used;
  logic        retire_v;
  logic        retire_ok;
  logic        retire_bad;
  logic [31:0] wb_hit;
  logic [31:0] eff_pend;
  logic        rd_nz;
  logic        full;
  logic        raw1;
  logic        raw2;
  logic        waw;
  logic        cap;
  logic        live;
  logic        issue;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // Operand usage by opcode class
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    unique case (id_opcode_i)
      OP_JAL, OP_LUI, OP_AUIPC: rs1_used = 1'b0;
      OP_R, OP_STORE, OP_BRANCH, OP_PIM: rs2_used = 1'b1;
      default: ;
    endcase
  end

  assign retire_v = wb_reg_write_i & wb_long_lat_i
                  & (wb_rd_i != 5'd0);
  assign wb_hit   = retire_v ? (32'd1 << wb_rd_i) : 32'd0;

  // A register retiring this cycle is forwarded, so it no longer blocks.
  assign eff_pend = pending_q & ~wb_hit;

  assign rd_nz = (id_rd_i != 5'd0);
  assign full  = (cnt_q == MAX_CNT);

  assign raw1 = rs1_used & eff_pend[id_rs1_i];
  assign raw2 = rs2_used & eff_pend[id_rs2_i];
  assign waw  = rd_nz & eff_pend[id_rd_i];
  assign cap  = id_long_lat_i & rd_nz & full & ~retire_v;

  assign live    = id_valid_i & ~flush_i;
  assign stall_o = live & (raw1 | raw2 | waw | cap);
  assign issue   = live & ~stall_o & id_long_lat_i & rd_nz;

  // A retire is only honoured against a register we actually track.
  assign retire_ok  = retire_v & pending_q[wb_rd_i];
  assign retire_bad = retire_v & ~pending_q[wb_rd_i];

  assign set_vec = issue ? (32'd1 << id_rd_i) : 32'd0;
  assign clr_vec = retire_ok ? (32'd1 << wb_rd_i) : 32'd0;

  // Set after clear: a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
    err_d     = err_q | retire_bad;
    cnt_d     = cnt_q;
    unique case ({issue, retire_ok})
      2'b10: if (cnt_q != MAX_CNT) cnt_d = cnt_q + ONE_CNT;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - ONE_CNT;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o     = pending_q;
  assign outstanding_o = cnt_q;
  assign full_o        = full;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic,
// expected results queued at drive time and popped at sample time.
module tb_hazard_scoreboard;

  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] ROP    = 7'b0110011;
  localparam logic [6:0] PIM    = 7'b0001011;
  localparam logic [6:0] OPIMM  = 7'b0010011;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          id_valid_i = 1'b0;
  logic [6:0]    id_opcode_i = '0;
  logic [4:0]    id_rs1_i = '0;
  logic [4:0]    id_rs2_i = '0;
  logic [4:0]    id_rd_i = '0;
  logic          id_long_lat_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          wb_reg_write_i = 1'b0;
  logic [4:0]    wb_rd_i = '0;
  logic          wb_long_lat_i = 1'b0;
  logic          stall_o;
  logic [31:0]   pending_o;
  logic [CW-1:0] outstanding_o;
  logic          full_o;
  logic          err_o;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_long_lat_i(id_long_lat_i), .flush_i(flush_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i),
    .wb_long_lat_i(wb_long_lat_i),
    .stall_o(stall_o), .pending_o(pending_o),
    .outstanding_o(outstanding_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        stall;
    logic [31:0] pend;
    int          cnt;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  // reference state
  bit m_pend[32];
  int m_cnt;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // One cycle: drive at negedge, check stall before posedge,
  // check registered state just after posedge.
  task automatic step(input string tag, input logic v,
                      input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd,
                      input logic ll, input logic fl, input logic ww,
                      input logic [4:0] wrd, input logic wll);
    exp_t e;
    bit u1, u2, ret, blk1, blk2, blkd, cp, st, iss, dec;
    @(negedge clk_i);
    id_valid_i = v; id_opcode_i = op;
    id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
    id_long_lat_i = ll; flush_i = fl;
    wb_reg_write_i = ww; wb_rd_i = wrd; wb_long_lat_i = wll;

    u1 = !(op == JAL || op == LUI || op == AUIPC);
    u2 = (op == ROP || op == STORE || op == BRANCH || op == PIM);
    ret = ww && wll && (wrd != 0);
    blk1 = r1 != 0 && m_pend[r1] && !(ret && wrd == r1);
    blk2 = r2 != 0 && m_pend[r2] && !(ret && wrd == r2);
    blkd = rd != 0 && m_pend[rd] && !(ret && wrd == rd);
    cp = ll && rd != 0 && m_cnt == MAXO && !ret;
    st = v && !fl && ((u1 && blk1) || (u2 && blk2) || blkd || cp);
    iss = v && !fl && !st && ll && rd != 0;
    dec = 0;
    if (ret) begin
      if (m_pend[wrd]) begin
        m_pend[wrd] = 0;
        dec = 1;
      end else begin
        m_err = 1;
      end
    end
    if (iss) m_pend[rd] = 1;
    if (iss && !dec) begin
      if (m_cnt < MAXO) m_cnt++;
    end else if (dec && !iss && m_cnt > 0) begin
      m_cnt--;
    end
    e.tag = tag; e.stall = st; e.pend = m_vec();
    e.cnt = m_cnt; e.full = (m_cnt == MAXO); e.err = m_err;
    exp_q.push_back(e);

    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".stall"}, 32'(stall_o), 32'(e.stall));
    @(posedge clk_i);
    #1;
    chk({e.tag, ".pend"}, pending_o, e.pend);
    chk({e.tag, ".cnt"}, 32'(outstanding_o), 32'(e.cnt));
    chk({e.tag, ".full"}, 32'(full_o), 32'(e.full));
    chk({e.tag, ".err"}, 32'(err_o), 32'(e.err));
  endtask

  task automatic issue_ld(input string tag, input logic [4:0] rd);
    step(tag, 1, LOAD, 5'd0, 5'd0, rd, 1, 0, 0, 5'd0, 0);
  endtask

  task automatic retire(input string tag, input logic [4:0] rd);
    step(tag, 0, OPIMM, 5'd0, 5'd0, 5'd0, 0, 0, 1, rd, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".pend"}, pending_o, 32'd0);
    chk({tag, ".cnt"}, 32'(outstanding_o), 32'd0);
    chk({tag, ".full"}, 32'(full_o), 32'd0);
    chk({tag, ".err"}, 32'(err_o), 32'd0);
  endtask

  task automatic idle_inputs();
    id_valid_i = 0; id_opcode_i = OPIMM; id_rs1_i = 0; id_rs2_i = 0;
    id_rd_i = 0; id_long_lat_i = 0; flush_i = 0;
    wb_reg_write_i = 0; wb_rd_i = 0; wb_long_lat_i = 0;
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{LOAD, STORE, BRANCH, JAL, LUI, AUIPC, ROP, PIM, OPIMM};
    m_reset();
    idle_inputs();
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("reset");
    @(negedge clk_i);
    rst_i = 0;

    // load-use
    issue_ld("ld_x5", 5'd5);
    chk("ld_x5.pend_lit", pending_o, 32'h20);
    step("add_stall", 1, ROP, 5'd5, 5'd7, 5'd6, 0, 0, 0, 5'd0, 0);
    chk("add_stall.cnt_lit", 32'(outstanding_o), 32'd1);
    step("add_fwd", 1, ROP, 5'd5, 5'd7, 5'd6, 0, 0, 1, 5'd5, 1);
    chk("add_fwd.pend_lit", pending_o, 32'h0);

    // operand usage
    issue_ld("ld_x5b", 5'd5);
    step("lui_rs1", 1, LUI, 5'd5, 5'd5, 5'd1, 0, 0, 0, 5'd0, 0);
    step("jal_waw", 1, JAL, 5'd5, 5'd5, 5'd5, 0, 0, 0, 5'd0, 0);
    step("opimm_rs2", 1, OPIMM, 5'd3, 5'd5, 5'd2, 0, 0, 0, 5'd0, 0);
    step("st_rs2", 1, STORE, 5'd3, 5'd5, 5'd0, 0, 0, 0, 5'd0, 0);
    retire("ret_x5", 5'd5);

    // capacity
    for (int i = 1; i <= 4; i++) issue_ld($sformatf("ld_x%0d", i), 5'(i));
    chk("full_lit", 32'(full_o), 32'd1);
    step("cap1", 1, LOAD, 5'd0, 5'd0, 5'd8, 1, 0, 0, 5'd0, 0);
    step("cap2", 1, LOAD, 5'd0, 5'd0, 5'd8, 1, 0, 0, 5'd0, 0);
    step("cap_ret", 1, LOAD, 5'd0, 5'd0, 5'd8, 1, 0, 1, 5'd1, 1);
    chk("cap_ret.cnt_lit", 32'(outstanding_o), 32'd4);
    step("nonll_wb", 0, OPIMM, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'd2, 0);
    retire("dr2", 5'd2); retire("dr3", 5'd3);
    retire("dr4", 5'd4); retire("dr8", 5'd8);

    // reissue + bad retire
    issue_ld("ld_x9", 5'd9);
    step("reiss_x9", 1, LOAD, 5'd0, 5'd0, 5'd9, 1, 0, 1, 5'd9, 1);
    chk("reiss_x9.bit", 32'(pending_o[9]), 32'd1);
    retire("bad_x10", 5'd10);
    chk("bad_x10.err_lit", 32'(err_o), 32'd1);
    step("err_hold", 0, OPIMM, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    retire("ret_x9", 5'd9);

    // flush
    issue_ld("ld_x11", 5'd11);
    step("fl_haz", 1, ROP, 5'd11, 5'd0, 5'd6, 0, 1, 0, 5'd0, 0);
    step("fl_ld", 1, LOAD, 5'd0, 5'd0, 5'd12, 1, 1, 0, 5'd0, 0);
    issue_ld("ld_x12", 5'd12);
    issue_ld("ld_x13", 5'd13);
    step("x0_ld", 1, LOAD, 5'd0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 0);

    // async reset with 3 pending
    @(negedge clk_i);
    idle_inputs();
    #2 rst_i = 1;
    #1;
    chk_zero("arst");
    m_reset();
    @(negedge clk_i);
    rst_i = 0;

    // random traffic on a small register window
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic       ww;
      op = ops[$urandom_range(0, 8)];
      ww = ($urandom_range(0, 1) == 1);
      step($sformatf("rnd%0d", n), ($urandom_range(0, 3) != 0), op,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), (op == LOAD || op == PIM),
           ($urandom_range(0, 7) == 0), ww,
           5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
